// File: rtl/ds18b20_pkg.sv
// Shared DS18B20 definitions: function-byte codes, FSM state encoding,
// 50 MHz bus timing constants and small sizing helpers. The master driver
// imports the same package so both ends agree on codes and timing.
package ds18b20_pkg;

   // Function / ROM command bytes
   localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
   localparam logic [7:0] CMD_CONVERT  = 8'h44;
   localparam logic [7:0] CMD_READ_SP  = 8'hBE;

   // Bus timing in 50 MHz clock cycles
   localparam int T_RST_MIN_50M   = 24_000;      // 480 us reset recognition
   localparam int T_PRES_WAIT_50M = 1_500;       // 30 us release-to-presence
   localparam int T_PRES_LOW_50M  = 6_000;       // 120 us presence low
   localparam int T_SAMPLE_50M    = 1_500;       // 30 us write-slot sample point
   localparam int T_TX0_HOLD_50M  = 2_000;       // 40 us low hold for a read-0
   localparam int T_CONV_50M      = 37_500_000;  // 750 ms conversion

   // Power-up temperature register (+85 C)
   localparam logic [15:0] T_RESET_VAL_DEF = 16'h0550;

   // Slave FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRES_WAIT,
      ST_PRES_LOW,
      ST_ROM_RX,
      ST_FN_RX,
      ST_TX
   } ds_state_e;

   // Bits needed for a counter that must hold values 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/onewire_bus_monitor.sv
// 1-Wire line watcher: synchronises dq, produces fall/rise strobes and flags
// a bus reset when the line rises after being low for at least T_RST_MIN.
module onewire_bus_monitor
   import ds18b20_pkg::*;
#(
   parameter int T_RST_MIN = T_RST_MIN_50M
)(
   input  logic clk,
   input  logic rst_n,
   input  logic dq_in,
   output logic dq_sync,
   output logic fall,
   output logic bus_reset
);

   localparam int LW = cnt_width(T_RST_MIN);

   logic          meta_reg;
   logic          sync_reg;
   logic          sync_d_reg;
   logic [LW-1:0] low_cnt_reg;
   logic          rise;

   // Two-stage synchroniser plus one delay stage for edge detection; idle bus is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg   <= 1'b1;
         sync_reg   <= 1'b1;
         sync_d_reg <= 1'b1;
      end else begin
         meta_reg   <= dq_in;
         sync_reg   <= meta_reg;
         sync_d_reg <= sync_reg;
      end
   end

   // Low-time counter: counts while the synchronised line is low, saturates at T_RST_MIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt_reg <= '0;
      end else if (sync_reg) begin
         low_cnt_reg <= '0;
      end else if (low_cnt_reg != LW'(T_RST_MIN)) begin
         low_cnt_reg <= low_cnt_reg + 1'b1;
      end
   end

   assign dq_sync   = sync_reg;
   assign fall      = sync_d_reg & ~sync_reg;
   assign rise      = ~sync_d_reg & sync_reg;
   // The counter still holds the completed low time on the rise cycle
   assign bus_reset = rise && (low_cnt_reg == LW'(T_RST_MIN));

endmodule

// File: rtl/ds18b20_slave_model.sv
// DS18B20 emulator: answers bus resets with a presence pulse, receives the
// ROM and function bytes LSB-first, runs the conversion timer and returns the
// 16-bit temperature over read slots. Open-drain: dq is only ever 0 or Z.
module ds18b20_slave_model
   import ds18b20_pkg::*;
#(
   parameter int          T_RST_MIN   = T_RST_MIN_50M,
   parameter int          T_PRES_WAIT = T_PRES_WAIT_50M,
   parameter int          T_PRES_LOW  = T_PRES_LOW_50M,
   parameter int          T_SAMPLE    = T_SAMPLE_50M,
   parameter int          T_TX0_HOLD  = T_TX0_HOLD_50M,
   parameter int          T_CONV      = T_CONV_50M,
   parameter logic [15:0] T_RESET_VAL = T_RESET_VAL_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   inout  wire         dq,
   input  logic [15:0] t_set,
   output logic [7:0]  cmd_code,
   output logic        cmd_valid,
   output logic        conv_busy,
   output logic        pres_done
);

   // One width covers every bus-timing counter
   localparam int TW = cnt_width(max_of(max_of(T_PRES_WAIT, T_PRES_LOW),
                                        max_of(T_SAMPLE, T_TX0_HOLD)));
   localparam int CW = cnt_width(T_CONV);

   ds_state_e     state_reg;
   logic [TW-1:0] pres_cnt_reg;
   logic          slot_active_reg;
   logic [TW-1:0] slot_cnt_reg;
   logic [2:0]    bit_cnt_reg;
   logic [6:0]    rx_shift_reg;
   logic [15:0]   tx_shift_reg;
   logic          tx_hold_reg;
   logic [TW-1:0] hold_cnt_reg;
   logic          dq_low_reg;
   logic [7:0]    cmd_code_reg;
   logic          cmd_valid_reg;
   logic          pres_done_reg;
   logic          conv_busy_reg;
   logic [CW-1:0] conv_cnt_reg;
   logic [15:0]   temp_reg;

   logic          dq_sync;
   logic          fall;
   logic          bus_reset;
   logic          rx_state;
   logic          sample_now;
   logic [7:0]    rx_byte_next;
   logic          conv_start;

   onewire_bus_monitor #(
      .T_RST_MIN (T_RST_MIN)
   ) u_mon (
      .clk       (clk),
      .rst_n     (rst_n),
      .dq_in     (dq),
      .dq_sync   (dq_sync),
      .fall      (fall),
      .bus_reset (bus_reset)
   );

   assign rx_state     = (state_reg == ST_ROM_RX) || (state_reg == ST_FN_RX);
   assign sample_now   = rx_state && slot_active_reg && (slot_cnt_reg == TW'(T_SAMPLE));
   // Bits arrive LSB-first, so each new sample enters at the top
   assign rx_byte_next = {dq_sync, rx_shift_reg};
   assign conv_start   = !bus_reset && sample_now && (bit_cnt_reg == 3'd7) &&
                         (state_reg == ST_FN_RX) && (rx_byte_next == CMD_CONVERT);

   // Main protocol FSM: presence, write-slot receive, read-slot transmit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         pres_cnt_reg    <= '0;
         slot_active_reg <= 1'b0;
         slot_cnt_reg    <= '0;
         bit_cnt_reg     <= '0;
         rx_shift_reg    <= '0;
         tx_shift_reg    <= '1;
         tx_hold_reg     <= 1'b0;
         hold_cnt_reg    <= '0;
         dq_low_reg      <= 1'b0;
         cmd_code_reg    <= '0;
         cmd_valid_reg   <= 1'b0;
         pres_done_reg   <= 1'b0;
      end else begin
         cmd_valid_reg <= 1'b0;
         pres_done_reg <= 1'b0;
         if (bus_reset) begin
            // A bus reset wins from any state, even mid-byte or mid-hold
            state_reg       <= ST_PRES_WAIT;
            pres_cnt_reg    <= '0;
            slot_active_reg <= 1'b0;
            slot_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            tx_shift_reg    <= '1;
            tx_hold_reg     <= 1'b0;
            hold_cnt_reg    <= '0;
            dq_low_reg      <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  // Slots are ignored until the next bus reset
               end
               ST_PRES_WAIT: begin
                  if (pres_cnt_reg == TW'(T_PRES_WAIT - 1)) begin
                     state_reg    <= ST_PRES_LOW;
                     pres_cnt_reg <= '0;
                     dq_low_reg   <= 1'b1;
                  end else begin
                     pres_cnt_reg <= pres_cnt_reg + 1'b1;
                  end
               end
               ST_PRES_LOW: begin
                  if (pres_cnt_reg == TW'(T_PRES_LOW - 1)) begin
                     state_reg       <= ST_ROM_RX;
                     pres_cnt_reg    <= '0;
                     dq_low_reg      <= 1'b0;
                     pres_done_reg   <= 1'b1;
                     slot_active_reg <= 1'b0;
                     bit_cnt_reg     <= '0;
                  end else begin
                     pres_cnt_reg <= pres_cnt_reg + 1'b1;
                  end
               end
               ST_ROM_RX, ST_FN_RX: begin
                  if (sample_now) begin
                     slot_active_reg <= 1'b0;
                     rx_shift_reg    <= rx_byte_next[7:1];
                     if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_reg <= '0;
                        if (state_reg == ST_ROM_RX) begin
                           state_reg <= (rx_byte_next == CMD_SKIP_ROM) ? ST_FN_RX : ST_IDLE;
                        end else begin
                           cmd_code_reg  <= rx_byte_next;
                           cmd_valid_reg <= 1'b1;
                           if (rx_byte_next == CMD_READ_SP) begin
                              tx_shift_reg <= temp_reg;
                              state_reg    <= ST_TX;
                           end else begin
                              // Convert is started by the conversion block; all else idles
                              state_reg <= ST_IDLE;
                           end
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end else if (slot_active_reg) begin
                     slot_cnt_reg <= slot_cnt_reg + 1'b1;
                  end else if (fall) begin
                     slot_active_reg <= 1'b1;
                     slot_cnt_reg    <= TW'(1);
                  end
               end
               ST_TX: begin
                  if (tx_hold_reg) begin
                     // Falls during the hold are overlapping slots and are ignored
                     if (hold_cnt_reg == TW'(T_TX0_HOLD - 1)) begin
                        tx_hold_reg <= 1'b0;
                        dq_low_reg  <= 1'b0;
                     end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                     end
                  end else if (fall) begin
                     // Refill with 1s so reads past bit 15 return 1
                     tx_shift_reg <= {1'b1, tx_shift_reg[15:1]};
                     if (!tx_shift_reg[0]) begin
                        tx_hold_reg  <= 1'b1;
                        hold_cnt_reg <= '0;
                        dq_low_reg   <= 1'b1;
                     end
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   // Conversion timer: independent of bus resets, restarted by a repeat Convert
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_busy_reg <= 1'b0;
         conv_cnt_reg  <= '0;
         temp_reg      <= T_RESET_VAL;
      end else if (conv_start) begin
         conv_busy_reg <= 1'b1;
         conv_cnt_reg  <= '0;
      end else if (conv_busy_reg) begin
         if (conv_cnt_reg == CW'(T_CONV - 1)) begin
            conv_busy_reg <= 1'b0;
            temp_reg      <= t_set;
         end else begin
            conv_cnt_reg <= conv_cnt_reg + 1'b1;
         end
      end
   end

   assign dq        = dq_low_reg ? 1'b0 : 1'bz;
   assign cmd_code  = cmd_code_reg;
   assign cmd_valid = cmd_valid_reg;
   assign conv_busy = conv_busy_reg;
   assign pres_done = pres_done_reg;

endmodule

// File: tb/tb_ds18b20_slave_model.sv
// Bench for ds18b20_slave_model with shortened bus timing. The bench plays
// the 1-Wire master; expected command bytes, presence pulses, conversion
// lengths and read words are queued by the stimulus and checked by monitors.
module tb_ds18b20_slave_model;

   localparam int P_RST_MIN   = 240;
   localparam int P_PRES_WAIT = 15;
   localparam int P_PRES_LOW  = 60;
   localparam int P_SAMPLE    = 15;
   localparam int P_TX0_HOLD  = 20;
   localparam int P_CONV      = 500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] t_set = 16'h0000;
   logic [7:0]  cmd_code;
   logic        cmd_valid;
   logic        conv_busy;
   logic        pres_done;
   logic        m_low = 1'b0;
   tri1         dq;

   assign dq = m_low ? 1'b0 : 1'bz;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_cmd_q[$];
   int          exp_pres_q[$];
   int          exp_conv_q[$];
   logic [15:0] exp_rd_q[$];
   logic [15:0] rd_word;
   event        rd_ev;
   int          busy_len = 0;

   always #10 clk = ~clk;

   ds18b20_slave_model #(
      .T_RST_MIN   (P_RST_MIN),
      .T_PRES_WAIT (P_PRES_WAIT),
      .T_PRES_LOW  (P_PRES_LOW),
      .T_SAMPLE    (P_SAMPLE),
      .T_TX0_HOLD  (P_TX0_HOLD),
      .T_CONV      (P_CONV),
      .T_RESET_VAL (16'h0550)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dq        (dq),
      .t_set     (t_set),
      .cmd_code  (cmd_code),
      .cmd_valid (cmd_valid),
      .conv_busy (conv_busy),
      .pres_done (pres_done)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   // Master reset pulse, then presence window checks
   task automatic bus_reset_pulse();
      exp_pres_q.push_back(1);
      m_low = 1'b1;
      tick(300);
      m_low = 1'b0;
      tick(40);
      check("presence_low", {31'd0, dq}, 32'd0);
      tick(60);
      check("presence_released", {31'd0, dq}, 32'd1);
      tick(10);
   endtask

   task automatic write_bit(input logic b);
      m_low = 1'b1;
      tick(b ? 3 : 40);
      m_low = 1'b0;
      tick(b ? 47 : 10);
   endtask

   task automatic write_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) write_bit(v[i]);
   endtask

   task automatic read_bits(input int n, input logic [15:0] exp);
      logic [15:0] w;
      w = '0;
      exp_rd_q.push_back(exp);
      for (int i = 0; i < n; i++) begin
         m_low = 1'b1;
         tick(5);
         m_low = 1'b0;
         tick(5);
         w[i] = dq;
         tick(25);
      end
      rd_word = w;
      -> rd_ev;
   endtask

   task automatic wait_conv();
      int n;
      n = 0;
      while (conv_busy && n < P_CONV + 100) begin
         tick(1);
         n++;
      end
      if (conv_busy) begin
         checks++;
         errors++;
         $display("FAIL conv_timeout actual=busy expected=idle");
      end
      tick(5);
   endtask

   // Command monitor
   always @(negedge clk) begin
      if (cmd_valid) begin
         checks++;
         if (exp_cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected actual=%0h expected=none", cmd_code);
         end else begin
            logic [7:0] e;
            e = exp_cmd_q.pop_front();
            if (cmd_code !== e) begin
               errors++;
               $display("FAIL cmd_code actual=%0h expected=%0h", cmd_code, e);
            end else begin
               $display("ok   cmd_code value=%0h", cmd_code);
            end
         end
      end
   end

   // Presence-done monitor
   always @(negedge clk) begin
      if (pres_done) begin
         checks++;
         if (exp_pres_q.size() == 0) begin
            errors++;
            $display("FAIL pres_done_unexpected actual=1 expected=0");
         end else begin
            void'(exp_pres_q.pop_front());
            $display("ok   pres_done pulse");
         end
      end
   end

   // Conversion-length monitor
   always @(negedge clk) begin
      if (conv_busy) begin
         busy_len++;
      end else if (busy_len != 0) begin
         checks++;
         if (exp_conv_q.size() == 0) begin
            errors++;
            $display("FAIL conv_unexpected actual=%0d expected=none", busy_len);
         end else begin
            int e;
            e = exp_conv_q.pop_front();
            if (busy_len != e) begin
               errors++;
               $display("FAIL conv_len actual=%0d expected=%0d", busy_len, e);
            end else begin
               $display("ok   conv_len value=%0d", busy_len);
            end
         end
         busy_len = 0;
      end
   end

   // Read-word monitor
   initial begin
      forever begin
         @(rd_ev);
         checks++;
         if (exp_rd_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected actual=%0h expected=none", rd_word);
         end else begin
            logic [15:0] e;
            e = exp_rd_q.pop_front();
            if (rd_word !== e) begin
               errors++;
               $display("FAIL read_word actual=%0h expected=%0h", rd_word, e);
            end else begin
               $display("ok   read_word value=%0h", rd_word);
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      logic [15:0] tvec[3];
      tvec[0] = 16'h0000;
      tvec[1] = 16'hFF5E;
      tvec[2] = 16'h07D0;

      tick(3);
      check("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
      check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_conv_busy", {31'd0, conv_busy}, 32'd0);
      check("rst_pres_done", {31'd0, pres_done}, 32'd0);
      check("rst_dq_released", {31'd0, dq}, 32'd1);
      rst_n = 1'b1;
      tick(5);

      // Plain presence
      bus_reset_pulse();

      // Power-up value read, then bits past 16 read as 1
      bus_reset_pulse();
      write_byte(8'hCC);
      exp_cmd_q.push_back(8'hBE);
      write_byte(8'hBE);
      read_bits(16, 16'h0550);
      read_bits(4, 16'h000F);

      // Non-Skip ROM byte: slave goes silent
      bus_reset_pulse();
      write_byte(8'h33);
      write_byte(8'hBE);
      read_bits(8, 16'h00FF);

      // Convert with t_set=0x0191
      t_set = 16'h0191;
      bus_reset_pulse();
      write_byte(8'hCC);
      exp_cmd_q.push_back(8'h44);
      exp_conv_q.push_back(P_CONV);
      write_byte(8'h44);
      check("conv_busy_started", {31'd0, conv_busy}, 32'd1);
      wait_conv();
      t_set = 16'hDEAD;

      // Read back the converted value
      bus_reset_pulse();
      write_byte(8'hCC);
      exp_cmd_q.push_back(8'hBE);
      write_byte(8'hBE);
      read_bits(16, 16'h0191);
      read_bits(4, 16'h000F);

      // Bus reset after 3 bits of a function byte
      bus_reset_pulse();
      write_byte(8'hCC);
      write_bit(1'b0);
      write_bit(1'b1);
      write_bit(1'b1);
      bus_reset_pulse();
      write_byte(8'hCC);
      exp_cmd_q.push_back(8'hBE);
      write_byte(8'hBE);
      read_bits(16, 16'h0191);

      // Repeated convert/read cycles
      for (int k = 0; k < 3; k++) begin
         t_set = tvec[k];
         bus_reset_pulse();
         write_byte(8'hCC);
         exp_cmd_q.push_back(8'h44);
         exp_conv_q.push_back(P_CONV);
         write_byte(8'h44);
         wait_conv();
         t_set = 16'hA5A5;
         bus_reset_pulse();
         write_byte(8'hCC);
         exp_cmd_q.push_back(8'hBE);
         write_byte(8'hBE);
         read_bits(16, tvec[k]);
      end

      tick(50);
      check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
      check("pres_queue_drained", exp_pres_q.size(), 32'd0);
      check("conv_queue_drained", exp_conv_q.size(), 32'd0);
      check("read_queue_drained", exp_rd_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
